// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the multicycle RV32 control path: the controller
// state encoding, the opcodes it recognises, the datapath mux-select codes
// and the ALU operation codes.
package riscv_ctrl_pkg;

  localparam int INSTR_W_DEF = 32;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;

  // funct3 / funct7 values accepted by this core
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // result_src encodings
  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_DATA       = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  // alu_src_a encodings
  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_RS1 = 2'b01;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
// Combinational instruction-field decoder for the multicycle controller.
// Ports:
//   opcode      in  7  instr[6:0]
//   funct3      in  3  instr[14:12]
//   funct7      in  7  instr[31:25]
//   alu_control out 3  ALU op used in EXECR (add, or sub when funct7[5])
//   illegal     out 1  instruction is not one of lw, sw, addi, add, sub
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    // funct7[5] (instr[30]) distinguishes sub from add for R-type.
    alu_control = funct7[5] ? ALU_SUB : ALU_ADD;
    illegal     = 1'b0;
    case (opcode)
      OP_R:        illegal = (funct3 != F3_ADD) ||
                             ((funct7 != F7_BASE) && (funct7 != F7_ALT));
      OP_I:        illegal = (funct3 != F3_ADD);
      OP_LW, OP_SW: illegal = (funct3 != F3_WORD);
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for the multicycle RV32 core. Sequences one state per clock
// for lw, sw, addi, add and sub; halts (sticky) on anything else.
// Optional feature: define CTRL_PERF_CNT_EN to add the instret counter port.
// Ports:
//   clk                 in  1   clock, rising edge
//   reset               in  1   asynchronous, active-high; forces FETCH
//   instr               in  32  IR contents from the datapath
//   mem_write           out 1   memory write strobe
//   reg_write           out 1   register-file write strobe
//   ir_write            out 1   IR load strobe
//   pc_write            out 1   PC load strobe
//   instruction_or_data out 1   address select (0 pc, 1 result)
//   result_src          out 2   result mux select
//   alu_src_a           out 2   ALU A select
//   alu_src_b           out 2   ALU B select
//   alu_control         out 3   ALU operation
//   halted              out 1   high in HALT
//   state_dbg           out 4   current state encoding
//   instret             out 32  retired-instruction count (CTRL_PERF_CNT_EN only)
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  output logic               mem_write,
  output logic               reg_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               instruction_or_data,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic               halted,
  output logic [3:0]         state_dbg
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        instret
`endif
);

  state_t     state_reg;
  state_t     state_next;
  logic [6:0] opcode;
  logic [2:0] dec_alu_control;
  logic       dec_illegal;

  // Register-number and immediate fields are datapath concerns only.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign opcode = instr[6:0];

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (instr[14:12]),
    .funct7      (instr[31:25]),
    .alu_control (dec_alu_control),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next          = state_reg;
    mem_write           = 1'b0;
    reg_write           = 1'b0;
    ir_write            = 1'b0;
    pc_write            = 1'b0;
    instruction_or_data = 1'b0;
    result_src          = RES_ALU_OUT;
    alu_src_a           = SRCA_PC;
    alu_src_b           = SRCB_RS2;
    alu_control         = ALU_ADD;
    halted              = 1'b0;

    case (state_reg)
      S_FETCH: begin
        state_next = S_DECODE;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU_RESULT;
      end
      S_DECODE: begin
        // The decoder flags every unsupported opcode as illegal, so the
        // opcode case below only needs the legal encodings.
        if (dec_illegal) state_next = S_HALT;
        else begin
          case (opcode)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_R:         state_next = S_EXECR;
            OP_I:         state_next = S_EXECI;
            default:      state_next = S_HALT;
          endcase
        end
      end
      S_MEMADR: begin
        state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
      end
      S_MEMREAD: begin
        state_next          = S_MEMWB;
        instruction_or_data = 1'b1;
        result_src          = RES_ALU_OUT;
      end
      S_MEMWB: begin
        state_next = S_FETCH;
        reg_write  = 1'b1;
        result_src = RES_DATA;
      end
      S_MEMWRITE: begin
        state_next = S_FETCH;
        mem_write  = 1'b1;
      end
      S_EXECR: begin
        state_next  = S_ALUWB;
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = dec_alu_control;
      end
      S_EXECI: begin
        state_next = S_ALUWB;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
      end
      S_ALUWB: begin
        state_next = S_FETCH;
        reg_write  = 1'b1;
        result_src = RES_ALU_OUT;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_next = S_HALT;
    endcase

    // Reset gates the outputs combinationally so strobes drop the instant
    // reset rises, not at the next clock edge (state already reads FETCH).
    if (reset) begin
      mem_write           = 1'b0;
      reg_write           = 1'b0;
      ir_write            = 1'b0;
      pc_write            = 1'b0;
      instruction_or_data = 1'b0;
      result_src          = RES_ALU_OUT;
      alu_src_a           = SRCA_PC;
      alu_src_b           = SRCB_RS2;
      alu_control         = ALU_ADD;
      halted              = 1'b0;
    end
  end

  assign state_dbg = state_reg;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret_reg;

  // Every writeback/store state is the final state of an instruction and
  // always exits to FETCH, so being in one of them at an edge means retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) instret_reg <= 32'd0;
    else if ((state_reg == S_MEMWB) || (state_reg == S_MEMWRITE) ||
             (state_reg == S_ALUWB))
      instret_reg <= instret_reg + 32'd1;
  end

  assign instret = instret_reg;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        mem_write, reg_write, ir_write, pc_write, instruction_or_data;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  alu_control;
  logic        halted;
  logic [3:0]  state_dbg;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .instr               (instr),
    .mem_write           (mem_write),
    .reg_write           (reg_write),
    .ir_write            (ir_write),
    .pc_write            (pc_write),
    .instruction_or_data (instruction_or_data),
    .result_src          (result_src),
    .alu_src_a           (alu_src_a),
    .alu_src_b           (alu_src_b),
    .alu_control         (alu_control),
    .halted              (halted),
    .state_dbg           (state_dbg)
`ifdef CTRL_PERF_CNT_EN
    ,
    .instret             (instret)
`endif
  );

  // Reset for two cycles, release after a falling edge; returns 1 ns later.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr = 32'h00500093;
    @(negedge clk);
    #1;
    checks++;
    if (state_dbg !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 ||
        alu_src_b !== 2'b00 || result_src !== 2'b00 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: state=%0d ir_write=%b pc_write=%b srcb=%b res=%b halted=%b, expected 0 0 0 00 00 0",
               state_dbg, ir_write, pc_write, alu_src_b, result_src, halted);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (state_dbg !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1 ||
        alu_src_b !== 2'b01 || result_src !== 2'b10) begin
      errors++;
      $display("FAIL reset_fetch: state=%0d ir_write=%b pc_write=%b srcb=%b res=%b, expected 0 1 1 01 10",
               state_dbg, ir_write, pc_write, alu_src_b, result_src);
    end
    $display("reset: released, state=%0d", state_dbg);
  endtask

  task automatic test_addi();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    do_reset();
    instr = 32'h00500093;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      checks++;
      if (state_dbg !== exp_st[c]) begin
        errors++;
        $display("FAIL addi_state c%0d: got %0d expected %0d", c, state_dbg, exp_st[c]);
      end
      checks++;
      if (reg_write !== (c == 3)) begin
        errors++;
        $display("FAIL addi_reg_write c%0d: got %b expected %b", c, reg_write, (c == 3));
      end
      if (c == 2) begin
        checks++;
        if (alu_src_b !== 2'b10 || alu_src_a !== 2'b01) begin
          errors++;
          $display("FAIL addi_execi_src: a=%b b=%b expected 01 10", alu_src_a, alu_src_b);
        end
      end
    end
    $display("addi 0x00500093: done");
  endtask

  task automatic test_add_sub();
    logic [31:0] ins [2] = '{32'h002081B3, 32'h402081B3};
    logic [2:0]  op  [2] = '{3'b000, 3'b001};
    logic [3:0]  exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      instr = ins[k];
      for (int c = 0; c < 5; c++) begin
        if (c > 0) step();
        checks++;
        if (state_dbg !== exp_st[c]) begin
          errors++;
          $display("FAIL rtype_state %h c%0d: got %0d expected %0d", ins[k], c, state_dbg, exp_st[c]);
        end
        if (c == 2) begin
          checks++;
          if (alu_control !== op[k] || alu_src_b !== 2'b00 || alu_src_a !== 2'b01) begin
            errors++;
            $display("FAIL rtype_execr %h: alu_control=%b a=%b b=%b expected %b 01 00",
                     ins[k], alu_control, alu_src_a, alu_src_b, op[k]);
          end
        end
      end
      $display("rtype %h: done", ins[k]);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset();
    instr = 32'h00802283;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      checks++;
      if (state_dbg !== exp_st[c]) begin
        errors++;
        $display("FAIL lw_state c%0d: got %0d expected %0d", c, state_dbg, exp_st[c]);
      end
      checks++;
      if (instruction_or_data !== (c == 3)) begin
        errors++;
        $display("FAIL lw_iord c%0d: got %b expected %b", c, instruction_or_data, (c == 3));
      end
      if (c == 4) begin
        checks++;
        if (result_src !== 2'b01 || reg_write !== 1'b1) begin
          errors++;
          $display("FAIL lw_memwb: result_src=%b reg_write=%b expected 01 1", result_src, reg_write);
        end
      end
    end
    $display("lw 0x00802283: done");
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    int mw = 0;
    int rw = 0;
    do_reset();
    instr = 32'h00502623;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      checks++;
      if (state_dbg !== exp_st[c]) begin
        errors++;
        $display("FAIL sw_state c%0d: got %0d expected %0d", c, state_dbg, exp_st[c]);
      end
      if (c < 4) begin
        mw += int'(mem_write);
        rw += int'(reg_write);
      end
    end
    checks++;
    if (mw != 1) begin
      errors++;
      $display("FAIL sw_mem_write_count: got %0d expected 1", mw);
    end
    checks++;
    if (rw != 0) begin
      errors++;
      $display("FAIL sw_reg_write_count: got %0d expected 0", rw);
    end
    $display("sw 0x00502623: done");
  endtask

  task automatic test_illegal();
    logic [31:0] ins [4] = '{32'hFFFFFFFF, 32'h00501093, 32'h202081B3, 32'h00801283};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      instr = ins[k];
      step();
      checks++;
      if (state_dbg !== 4'd1) begin
        errors++;
        $display("FAIL illegal_decode %h: got %0d expected 1", ins[k], state_dbg);
      end
      step();
      checks++;
      if (state_dbg !== 4'd9 || halted !== 1'b1) begin
        errors++;
        $display("FAIL illegal_halt %h: state=%0d halted=%b expected 9 1", ins[k], state_dbg, halted);
      end
      $display("illegal %h: halted", ins[k]);
    end
    // Sticky HALT with everything quiet; a legal instr must not restart it.
    instr = 32'h00500093;
    for (int c = 0; c < 22; c++) begin
      step();
      checks++;
      if (halted !== 1'b1 || state_dbg !== 4'd9 || mem_write !== 1'b0 || reg_write !== 1'b0 ||
          ir_write !== 1'b0 || pc_write !== 1'b0) begin
        errors++;
        $display("FAIL halt_sticky c%0d: state=%0d halted=%b mw=%b rw=%b irw=%b pcw=%b expected 9 1 0 0 0 0",
                 c, state_dbg, halted, mem_write, reg_write, ir_write, pc_write);
      end
    end
    do_reset();
    checks++;
    if (state_dbg !== 4'd0 || halted !== 1'b0 || ir_write !== 1'b1) begin
      errors++;
      $display("FAIL halt_reset: state=%0d halted=%b ir_write=%b expected 0 0 1", state_dbg, halted, ir_write);
    end
    $display("halt: released by reset");
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr = 32'h00802283;
    step(); step(); step();
    checks++;
    if (state_dbg !== 4'd3 || instruction_or_data !== 1'b1) begin
      errors++;
      $display("FAIL mid_memread: state=%0d iord=%b expected 3 1", state_dbg, instruction_or_data);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state_dbg !== 4'd0 || instruction_or_data !== 1'b0 || reg_write !== 1'b0 ||
        ir_write !== 1'b0 || pc_write !== 1'b0 || result_src !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: state=%0d iord=%b rw=%b irw=%b pcw=%b res=%b expected 0 0 0 0 0 00",
               state_dbg, instruction_or_data, reg_write, ir_write, pc_write, result_src);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("reset mid-MEMREAD: aborted");
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic test_instret();
    do_reset();
    checks++;
    if (instret !== 32'd0) begin
      errors++;
      $display("FAIL instret_reset: got %0d expected 0", instret);
    end
    instr = 32'h00500093;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (instret !== 32'd1) begin
      errors++;
      $display("FAIL instret_one: got %0d expected 1", instret);
    end
    instr = 32'h00502623;
    for (int c = 0; c < 4; c++) step();
    instr = 32'h00802283;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (instret !== 32'd3) begin
      errors++;
      $display("FAIL instret_three: got %0d expected 3", instret);
    end
    instr = 32'hFFFFFFFF;
    for (int c = 0; c < 12; c++) step();
    checks++;
    if (instret !== 32'd3) begin
      errors++;
      $display("FAIL instret_halt: got %0d expected 3", instret);
    end
    $display("instret: %0d", instret);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_add_sub();
    test_lw();
    test_sw();
    test_illegal();
    test_reset_mid();
`ifdef CTRL_PERF_CNT_EN
    test_instret();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
